// File: rtl/pcie_scramble_pkg.sv
// pcie_scramble_pkg: shared symbols, LFSR constants and the per-symbol LFSR step
package pcie_scramble_pkg;
  localparam logic [7:0] COM_SYM = 8'hBC;
  localparam logic [7:0] SKP_SYM = 8'h1C;
  localparam logic [15:0] LFSR_SEED = 16'hFFFF;
  localparam logic [15:0] LFSR_TAPS = 16'h0039;
  function automatic logic [15:0] lfsrStep(input logic [15:0] s);
    logic [15:0] r;
    r = s;
    for (int i = 0; i < 8; i++) r = {r[14:0], 1'b0} ^ (r[15] ? LFSR_TAPS : 16'h0000);
    return r;
  endfunction
  function automatic logic [7:0] bitRev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction
endpackage

// File: rtl/scramble_byte_step.sv
// scramble_byte_step: scrambles one symbol and advances the LFSR by one symbol
module scramble_byte_step
  import pcie_scramble_pkg::*;
#(
  parameter logic [15:0] SEED = LFSR_SEED
) (
  input  logic [15:0] State,
  input  logic [7:0]  Data,
  input  logic        IsK,
  input  logic        Disable,
  output logic [15:0] NextState,
  output logic [7:0]  Scrambled
);
  logic isCom;
  logic isSkp;
  // COM reloads the seed, SKP freezes the LFSR, every other symbol steps it
  always_comb begin
    isCom = IsK && (Data == COM_SYM);
    isSkp = IsK && (Data == SKP_SYM);
    NextState = isCom ? SEED : isSkp ? State : lfsrStep(State);
    Scrambled = (IsK || Disable) ? Data : Data ^ bitRev8(State[15:8]);
  end
endmodule

// File: rtl/multi_byte_scrambler.sv
// multi_byte_scrambler: PCIe-style LFSR scrambler processing BYTES symbols per word
module multi_byte_scrambler
  import pcie_scramble_pkg::*;
#(
  parameter int BYTES = 2,
  parameter logic [15:0] SEED = 16'hFFFF
) (
  input  logic               ClkPci,
  input  logic               notResetPci,
  input  logic               InValid,
  input  logic [8*BYTES-1:0] DataIn,
  input  logic [BYTES-1:0]   KIn,
  input  logic               Disable,
  output logic [8*BYTES-1:0] DataOut,
  output logic [BYTES-1:0]   KOut,
  output logic               OutValid,
  output logic [15:0]        LfsrState
);
  logic [15:0] chainState [0:BYTES];
  logic [8*BYTES-1:0] scrambled;
  assign chainState[0] = LfsrState;
  for (genvar i = 0; i < BYTES; i++) begin : gStep
    scramble_byte_step #(.SEED(SEED)) uStep (
      .State     (chainState[i]),
      .Data      (DataIn[8*i +: 8]),
      .IsK       (KIn[i]),
      .Disable   (Disable),
      .NextState (chainState[i+1]),
      .Scrambled (scrambled[8*i +: 8])
    );
  end
  // register one word per accepted cycle; outputs hold while InValid is low
  always_ff @(posedge ClkPci or negedge notResetPci) begin
    if (!notResetPci) begin
      LfsrState <= SEED;
      DataOut <= '0;
      KOut <= '0;
      OutValid <= 1'b0;
    end else begin
      OutValid <= InValid;
      if (InValid) begin
        LfsrState <= chainState[BYTES];
        DataOut <= scrambled;
        KOut <= KIn;
      end
    end
  end
endmodule

// File: tb/tb_multi_byte_scrambler.sv
// tb_multi_byte_scrambler: directed vectors plus randomized check against a keystream model
module tb_multi_byte_scrambler;
  logic ClkPci = 1'b0;
  logic notResetPci = 1'b1;
  logic InValid = 1'b0;
  logic Disable = 1'b0;
  logic [15:0] DataIn = '0;
  logic [1:0] KIn = '0;
  logic [15:0] DataOut;
  logic [15:0] LfsrState;
  logic [1:0] KOut;
  logic OutValid;
  int tests = 0;
  int fails = 0;
  logic [15:0] st [0:65534];
  int pos;
  logic [15:0] modelData;
  logic [1:0] modelK;
  logic modelValid;
  typedef struct {
    logic v; logic [1:0] k; logic [15:0] d; logic dis;
    logic [15:0] expD; logic [1:0] expK; logic expV;
  } vec_t;
  vec_t vecs [12];

  multi_byte_scrambler #(.BYTES(2), .SEED(16'hFFFF)) dut (
    .ClkPci      (ClkPci),
    .notResetPci (notResetPci),
    .InValid     (InValid),
    .DataIn      (DataIn),
    .KIn         (KIn),
    .Disable     (Disable),
    .DataOut     (DataOut),
    .KOut        (KOut),
    .OutValid    (OutValid),
    .LfsrState   (LfsrState)
  );

  always #5 ClkPci = ~ClkPci;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] keyByte(input int p);
    logic [7:0] b;
    for (int j = 0; j < 8; j++) b[j] = st[(p + j) % 65535][15];
    return b;
  endfunction

  task automatic drive(input logic v, input logic [1:0] k, input logic [15:0] d, input logic dis);
    InValid = v; KIn = k; DataIn = d; Disable = dis;
    @(posedge ClkPci); #1;
  endtask

  task automatic modelStep(input logic v, input logic [1:0] k, input logic [15:0] d, input logic dis);
    logic [7:0] b;
    if (v) begin
      for (int i = 0; i < 2; i++) begin
        b = d[8*i +: 8];
        if (k[i]) begin
          modelData[8*i +: 8] = b;
          if (b == 8'hBC) pos = 0;
          else if (b != 8'h1C) pos = (pos + 8) % 65535;
        end else begin
          modelData[8*i +: 8] = dis ? b : b ^ keyByte(pos);
          pos = (pos + 8) % 65535;
        end
      end
      modelK = k;
    end
    modelValid = v;
    drive(v, k, d, dis);
    check("mdl_data", DataOut, modelData);
    check("mdl_k", KOut, modelK);
    check("mdl_valid", OutValid, modelValid);
    check("mdl_lfsr", LfsrState, st[pos]);
  endtask

  task automatic resetPulse();
    notResetPci = 1'b0;
    #2;
    check("rst_data", DataOut, 16'h0);
    check("rst_k", KOut, 2'b00);
    check("rst_valid", OutValid, 1'b0);
    check("rst_lfsr", LfsrState, 16'hFFFF);
    @(posedge ClkPci); #1;
    notResetPci = 1'b1;
    pos = 0; modelData = '0; modelK = '0; modelValid = 1'b0;
  endtask

  initial begin
    logic [1:0] k;
    logic [15:0] d;
    int kind;
    st[0] = 16'hFFFF;
    for (int n = 1; n < 65535; n++)
      st[n] = {st[n-1][14:0], 1'b0} ^ (st[n-1][15] ? 16'h0039 : 16'h0000);
    vecs[0]  = '{1'b1, 2'b10, 16'hBC00, 1'b0, 16'hBCFF, 2'b10, 1'b1};
    vecs[1]  = '{1'b1, 2'b00, 16'h0000, 1'b0, 16'h17FF, 2'b00, 1'b1};
    vecs[2]  = '{1'b1, 2'b00, 16'h0000, 1'b0, 16'h14C0, 2'b00, 1'b1};
    vecs[3]  = '{1'b1, 2'b11, 16'h1CBC, 1'b0, 16'h1CBC, 2'b11, 1'b1};
    vecs[4]  = '{1'b1, 2'b01, 16'h001C, 1'b0, 16'hFF1C, 2'b01, 1'b1};
    vecs[5]  = '{1'b1, 2'b11, 16'hBCBC, 1'b1, 16'hBCBC, 2'b11, 1'b1};
    vecs[6]  = '{1'b1, 2'b00, 16'h0000, 1'b1, 16'h0000, 2'b00, 1'b1};
    vecs[7]  = '{1'b1, 2'b00, 16'h0000, 1'b0, 16'h14C0, 2'b00, 1'b1};
    vecs[8]  = '{1'b1, 2'b11, 16'hF7BC, 1'b0, 16'hF7BC, 2'b11, 1'b1};
    vecs[9]  = '{1'b1, 2'b00, 16'h0000, 1'b0, 16'hC017, 2'b00, 1'b1};
    vecs[10] = '{1'b0, 2'b11, 16'hABCD, 1'b0, 16'hC017, 2'b00, 1'b0};
    vecs[11] = '{1'b1, 2'b00, 16'h0000, 1'b0, 16'hB214, 2'b00, 1'b1};
    #2;
    resetPulse();
    check("seed_lfsr", LfsrState, 16'hFFFF);
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].v, vecs[i].k, vecs[i].d, vecs[i].dis);
      check($sformatf("vec%0d_data", i), DataOut, vecs[i].expD);
      check($sformatf("vec%0d_k", i), KOut, vecs[i].expK);
      check($sformatf("vec%0d_valid", i), OutValid, vecs[i].expV);
    end
    drive(1'b1, 2'b00, 16'h0000, 1'b0);
    InValid = 1'b1; DataIn = 16'h0000; KIn = 2'b00;
    #2;
    resetPulse();
    InValid = 1'b0;
    check("post_rst_lfsr", LfsrState, 16'hFFFF);
    drive(1'b1, 2'b00, 16'h0000, 1'b0);
    check("post_rst_data", DataOut, 16'h17FF);
    check("post_rst_valid", OutValid, 1'b1);
    #2;
    resetPulse();
    modelStep(1'b1, 2'b01, 16'h00BC, 1'b0);
    modelStep(1'b1, 2'b00, 16'h0000, 1'b0);
    for (int i = 0; i < 5; i++) modelStep(1'b0, 2'b00, 16'h5A5A, 1'b0);
    modelStep(1'b1, 2'b00, 16'h0000, 1'b0);
    modelStep(1'b1, 2'b00, 16'h0000, 1'b0);
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 2; i++) begin
        kind = $urandom_range(0, 11);
        k[i] = kind < 4;
        d[8*i +: 8] = kind == 0 ? 8'hBC : kind == 1 ? 8'h1C : kind == 2 ? 8'hF7 : 8'($urandom);
      end
      modelStep($urandom_range(0, 4) != 0, k, d, $urandom_range(0, 5) == 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/multi_byte_scrambler.md
MULTI_BYTE_SCRAMBLER -- requirements
Module: multi_byte_scrambler

Interface
REQ-001 Parameter BYTES, default 2, symbols per word (legal values 1, 2, 4).
REQ-002 Parameter SEED, default 16'hFFFF, LFSR load value on reset and on COM.
REQ-003 ClkPci  input  1  Single clock; all state updates on its rising edge.
REQ-004 notResetPci  input  1  Reset, asynchronous assertion, active-low.
REQ-005 InValid  input  1  Word qualifier; when 0, no state advances.
REQ-006 DataIn  input  8*BYTES  Symbols; byte 0 in bits [7:0] is earliest in time.
REQ-007 KIn  input  BYTES  Per-byte control flag; 1 = K symbol.
REQ-008 Disable  input  1  Scrambling disabled; sampled per word.
REQ-009 DataOut  output  8*BYTES  Registered scrambled symbols.
REQ-010 KOut  output  BYTES  Registered KIn.
REQ-011 OutValid  output  1  Registered InValid.
REQ-012 LfsrState  output  16  Registered LFSR value after the last accepted word.

Function
REQ-013 LFSR polynomial SHALL be G(X)=X^16+X^5+X^4+X^3+1; one symbol step = 8 serial shifts (Galois form, taps 3/4/5).
REQ-014 Per byte i, in ascending order, the block SHALL use the LFSR value S(i) left by byte i-1 (byte 0 uses LfsrState).
REQ-015 COM (KIn=1, 8'hBC): output unchanged; S(i+1)=SEED; no step.
REQ-016 SKP (KIn=1, 8'h1C): output unchanged; S(i+1)=S(i); no step.
REQ-017 Other K symbol: output unchanged; S(i+1)=step(S(i)).
REQ-018 Data byte (KIn=0): output = DataIn byte XOR bit-reverse(S(i)[15:8]) (S[15] to bit 0); S(i+1)=step(S(i)).
REQ-019 Disable=1: data bytes SHALL pass unscrambled; LFSR SHALL still follow REQ-015..018.
REQ-020 Latency: DataOut/KOut/OutValid SHALL appear exactly one ClkPci cycle after the accepting edge; throughput one word per cycle.
REQ-021 InValid=0: LfsrState held; OutValid=0; DataOut/KOut hold previous values.
REQ-022 Multiple COM/SKP in one word SHALL be processed sequentially; a later COM overrides all earlier state in that word.
REQ-023 LFSR SHALL wrap naturally (period 65535); no saturation or special case.
REQ-024 LfsrState SHALL update to S(BYTES) on every accepted word.

Reset
REQ-025 While notResetPci=0: LfsrState=SEED, DataOut=0, KOut=0, OutValid=0, regardless of clock.
REQ-026 Reset asserted mid-stream SHALL discard the in-flight word; first accepted word after deassertion uses SEED.
REQ-027 Deassertion SHALL be synchronised by the integrating level; the block has no internal reset synchroniser.

Structure
REQ-028 Package pcie_scramble_pkg SHALL hold COM_SYM=8'hBC, SKP_SYM=8'h1C, LFSR_SEED=16'hFFFF, LFSR_TAPS, and the single-symbol step function.
REQ-029 Sub-module scramble_byte_step (combinational: S, byte, K, Disable in; S next, byte out) SHALL be instantiated BYTES times in a generate chain.
REQ-030 Only LfsrState, DataOut, KOut, OutValid SHALL be registers.

Verification
REQ-031 BYTES=1: COM then data 00,00,00,00 -> DataOut FF,17,C0,14 after COM passes as BC.
REQ-032 BYTES=2: word {00,BC(K)} then {00,00} -> second word scrambles to {17,FF} (byte0=FF).
REQ-033 COM, SKP, SKP, data 00 -> SKPs pass as 1C, data byte out FF (LFSR not advanced by SKP).
REQ-034 Disable=1 with COM then 00,00 -> DataOut 00,00; then Disable=0, next 00 -> C0 (LFSR tracked).
REQ-035 InValid low 5 cycles mid-sequence -> OutValid low, LfsrState constant, sequence resumes unbroken.
REQ-036 Reset pulse between two data words -> all outputs 0 asynchronously, LfsrState=FFFF, next data 00 -> FF.
